// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial link receiver.
//   state_t    : receiver FSM encoding (ST_IDLE = 1'b0, ST_SHIFT = 1'b1)
//   LINK_WIDTH : default word width, shared with the transmitting PISO so
//                both ends of the link agree on framing.
package sipo_deserializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int LINK_WIDTH = 4;

endpackage : sipo_deserializer_pkg

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register for received words.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   wr_en, wr_data : a completed word is offered this cycle
//   rd_ready       : consumer accepts the held word
//   dout           : held word (don't-care while dout_valid = 0)
//   dout_valid     : register holds an unconsumed word
//   drop           : the offered word cannot be stored (register full and
//                    not draining this cycle)
module sipo_hold_reg
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             drop
);

    // A slot is free when empty or when its occupant leaves on this edge.
    logic slot_free;
    assign slot_free = !dout_valid || rd_ready;
    assign drop      = wr_en && !slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (wr_en && slot_free) begin
            dout       <= wr_data;
            dout_valid <= 1'b1;
        end else if (dout_valid && rd_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule : sipo_hold_reg

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver for the MSB-first PISO bit stream.
// A sampled bit with start=1 begins a word; WIDTH bits later the word is
// handed to a one-entry valid/ready holding register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   sin, sin_en  : serial bit and its sampling strobe
//   start        : marks the sampled bit as the MSB of a new word
//   dout         : received word, first bit in dout[WIDTH-1]
//   dout_valid   : dout holds an unconsumed word
//   dout_ready   : consumer accepts dout
//   busy         : a word is partially received
//   overrun      : sticky, a completed word was dropped (register full)
//   frame_err    : sticky, a partial word was aborted by start
//   clr_err      : clears both sticky flags (a same-edge set wins)
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    // Only the WIDTH-1 bits already received need storing; the last bit
    // comes straight from sin on the completing edge.
    logic [WIDTH-2:0]   sr;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   new_word;
    logic               last_bit;
    logic               complete;
    logic               abort;
    logic               drop;

    assign new_word = {sr, sin};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign complete = (state == ST_SHIFT) && sin_en && !start && last_bit;
    assign abort    = (state == ST_SHIFT) && sin_en && start;
    assign busy     = (state == ST_SHIFT);

    // Framing FSM, shifter and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (sin_en) begin
            if (start) begin
                // New MSB; any partial word (resync) is discarded.
                sr    <= (WIDTH-1)'(sin);
                cnt   <= CNT_W'(1);
                state <= ST_SHIFT;
            end else if (state == ST_SHIFT) begin
                sr <= new_word[WIDTH-2:0];
                if (last_bit) begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Sticky error flags; a set on the same edge as clr_err takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (complete && drop)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;

            if (abort)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
        end
    end

    // Output holding register
    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (complete),
        .wr_data    (new_word),
        .rd_ready   (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .drop       (drop)
    );

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH = 4).
module tb_sipo_deserializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sin;
    logic             sin_en;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             clr_err;

    int n_checks = 0;
    int n_errors = 0;

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_en     (sin_en),
        .start      (start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with a sampled bit; returns 1 ns after the edge.
    task automatic send_bit(input logic b, input logic st);
        sin    = b;
        sin_en = 1'b1;
        start  = st;
        @(posedge clk);
        #1;
        sin_en = 1'b0;
        start  = 1'b0;
    endtask

    // Idle clocks with sin toggling while sin_en is low.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sin_en = 1'b0;
            sin    = ~sin;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--)
            send_bit(w[i], i == 3);
    endtask

    task automatic check_flags(input string tag, input logic ov, input logic fe);
        check({tag, ".overrun"}, overrun, ov);
        check({tag, ".frame_err"}, frame_err, fe);
    endtask

    initial begin
        rst_n      = 1'b0;
        sin        = 1'b0;
        sin_en     = 1'b0;
        start      = 1'b0;
        dout_ready = 1'b0;
        clr_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // 1: load junk (held word 9, partial word, flags), then async reset
        send_word(4'h9);
        send_word(4'h3);           // dropped -> overrun
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);      // abort -> frame_err
        check("t1.junk_busy", busy, 1'b1);
        check("t1.junk_dout", dout, 4'h9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1.rst_dout", dout, 4'h0);
        check("t1.rst_valid", dout_valid, 1'b0);
        check("t1.rst_busy", busy, 1'b0);
        check_flags("t1.rst", 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        idle(1);
        check("t1.rel_busy", busy, 1'b0);
        check("t1.rel_valid", dout_valid, 1'b0);

        // 2: basic word 1101 with consumer always ready
        dout_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        check("t2.busy1", busy, 1'b1);
        check("t2.valid1", dout_valid, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t2.busy2", busy, 1'b1);
        send_bit(1'b0, 1'b0);
        check("t2.busy3", busy, 1'b1);
        check("t2.valid3", dout_valid, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t2.busy4", busy, 1'b0);
        check("t2.valid4", dout_valid, 1'b1);
        check("t2.dout", dout, 4'hD);
        idle(1);
        check("t2.valid_drop", dout_valid, 1'b0);
        check_flags("t2", 1'b0, 1'b0);

        // 3: overrun with consumer stalled, then drain and clear
        dout_ready = 1'b0;
        send_word(4'hD);
        check("t3.valid_first", dout_valid, 1'b1);
        check("t3.ovr_first", overrun, 1'b0);
        send_word(4'hA);
        check("t3.dout_held", dout, 4'hD);
        check("t3.valid_held", dout_valid, 1'b1);
        check("t3.ovr_set", overrun, 1'b1);
        dout_ready = 1'b1;
        idle(1);
        check("t3.valid_drained", dout_valid, 1'b0);
        check("t3.ovr_sticky", overrun, 1'b1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("t3.ovr_clr", overrun, 1'b0);

        // 4: full register drained on the completing edge -> no overrun
        dout_ready = 1'b0;
        send_word(4'hD);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        dout_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        check("t4.dout", dout, 4'hA);
        check("t4.valid", dout_valid, 1'b1);
        check("t4.ovr", overrun, 1'b0);
        idle(1);
        check("t4.valid_drop", dout_valid, 1'b0);

        // 5: resync abort sets frame_err; the restarted word is received
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_word(4'hA);
        check("t5.dout", dout, 4'hA);
        check("t5.valid", dout_valid, 1'b1);
        check_flags("t5", 1'b0, 1'b1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("t5.fe_clr", frame_err, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        clr_err = 1'b1;            // clear and abort on the same edge
        send_bit(1'b0, 1'b1);
        clr_err = 1'b0;
        check("t5.fe_set_wins", frame_err, 1'b1);
        check("t5.busy_resync", busy, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t5.dout_resync", dout, 4'h7);
        // back-to-back word with zero dead cycles
        send_word(4'h5);
        check("t5.dout_b2b", dout, 4'h5);
        check("t5.valid_b2b", dout_valid, 1'b1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;

        // 6: gaps between bits with sin toggling
        send_bit(1'b0, 1'b1);
        idle(2);
        check("t6.busy_gap", busy, 1'b1);
        send_bit(1'b1, 1'b0);
        idle(1);
        send_bit(1'b1, 1'b0);
        idle(3);
        check("t6.valid_gap", dout_valid, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t6.dout", dout, 4'h6);
        check("t6.valid", dout_valid, 1'b1);
        check_flags("t6", 1'b0, 1'b0);
        // reset mid-word discards it silently
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        idle(3);
        check("t6.rst_valid", dout_valid, 1'b0);
        check("t6.rst_busy", busy, 1'b0);
        check_flags("t6.rst", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sipo_deserializer
